// File: rtl/qutrit_op_sequencer.sv
// Command sequencer feeding the qutrit core: FIFO-buffered SU(3) op bursts with settle gaps and a resonance-loss fault.
// Optional: define QSEQ_H_DECAY_EN to halve h_input on each held cycle of a burst (annealed perturbation).
module qutrit_op_sequencer #(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned LOSS_LIMIT    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [31:0]              cmd_h,
   input  logic [7:0]               cmd_repeat,
   input  logic                     resonance_active,
   input  logic                     fault_clear,
   output logic [3:0]               q_op,
   output logic [31:0]              h_input,
   output logic                     busy,
   output logic                     fault,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [15:0]              ops_issued
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 2);
   localparam int unsigned LW = $clog2(LOSS_LIMIT + 1);

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] h;
      logic [7:0]  rpt;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_FAULT} state_t;

   state_t        state_q, state_d;
   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic [7:0]    cnt_q, cnt_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [LW-1:0] loss_q, loss_d;
   logic [3:0]    q_op_d;
   logic [31:0]   h_d;
   logic [15:0]   ops_d;
   logic          push, pop, flush, full, empty;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign cmd_ready  = !full && (state_q != S_FAULT);
   assign push       = cmd_valid && cmd_ready;
   assign head       = mem[rd_ptr];
   assign busy       = (state_q != S_IDLE) || !empty;
   assign fault      = (state_q == S_FAULT);
   assign fifo_count = count_q;

   // Command storage; a fault flush only rewinds the pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_op, cmd_h, cmd_repeat};
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         q_op       <= '0;
         h_input    <= '0;
         cnt_q      <= '0;
         settle_q   <= '0;
         loss_q     <= '0;
         ops_issued <= '0;
      end else begin
         state_q    <= state_d;
         q_op       <= q_op_d;
         h_input    <= h_d;
         cnt_q      <= cnt_d;
         settle_q   <= settle_d;
         loss_q     <= loss_d;
         ops_issued <= ops_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      q_op_d   = q_op;
      h_d      = h_input;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      loss_d   = loss_q;
      ops_d    = ops_issued;
      pop      = 1'b0;
      flush    = 1'b0;

      case (state_q)
         S_IDLE: begin
            loss_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               q_op_d  = head.op;
               h_d     = head.h;
               cnt_d   = head.rpt;
               state_d = S_ISSUE;
            end else begin
               q_op_d = '0;
               h_d    = '0;
            end
         end
         S_ISSUE: begin
            ops_d = ops_issued + 16'd1;
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
`ifdef QSEQ_H_DECAY_EN
               h_d   = h_input >> 1;
`else
               h_d   = h_input;
`endif
            end else begin
               q_op_d = '0;
               h_d    = '0;
               if (SETTLE_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d  = S_SETTLE;
                  settle_d = SW'(SETTLE_CYCLES - 1);
               end
            end
         end
         S_SETTLE: begin
            q_op_d = '0;
            h_d    = '0;
            if (settle_q == '0) state_d = S_IDLE;
            else                settle_d = settle_q - SW'(1);
         end
         S_FAULT: begin
            q_op_d = '0;
            h_d    = '0;
            loss_d = '0;
            if (fault_clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Resonance monitor overrides any burst-end decision made above
      if (state_q == S_ISSUE || state_q == S_SETTLE) begin
         if (resonance_active) begin
            loss_d = '0;
         end else if (loss_q == LW'(LOSS_LIMIT - 1)) begin
            state_d = S_FAULT;
            q_op_d  = '0;
            h_d     = '0;
            loss_d  = '0;
            flush   = 1'b1;
         end else begin
            loss_d = loss_q + LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_qutrit_op_sequencer.sv
// Directed self-checking bench for qutrit_op_sequencer at default parameters.
module tb_qutrit_op_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [31:0] cmd_h = '0;
   logic [7:0]  cmd_repeat = '0;
   logic        resonance_active = 1'b1;
   logic        fault_clear = 1'b0;
   logic [3:0]  q_op;
   logic [31:0] h_input;
   logic        busy;
   logic        fault;
   logic [3:0]  fifo_count;
   logic [15:0] ops_issued;

   int total = 0;
   int bad   = 0;

   qutrit_op_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_h(cmd_h), .cmd_repeat(cmd_repeat),
      .resonance_active(resonance_active), .fault_clear(fault_clear),
      .q_op(q_op), .h_input(h_input), .busy(busy), .fault(fault),
      .fifo_count(fifo_count), .ops_issued(ops_issued)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [31:0] h, input logic [7:0] rpt);
      cmd_op = op; cmd_h = h; cmd_repeat = rpt; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin tick(); n++; end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL %s_drain busy=%b want=0", name, busy); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      total++; if (q_op !== 4'h0)      begin bad++; $display("FAIL rst_q_op got=%h want=0", q_op); end
      total++; if (h_input !== 32'h0)  begin bad++; $display("FAIL rst_h got=%h want=0", h_input); end
      total++; if (fault !== 1'b0)     begin bad++; $display("FAIL rst_fault got=%b want=0", fault); end
      total++; if (ops_issued !== 16'h0) begin bad++; $display("FAIL rst_ops got=%0d want=0", ops_issued); end
      total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", fifo_count); end
      reset = 1'b0;
      tick();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
   endtask

   task automatic test_single();
      logic [31:0] exp_h = 32'h0002_0000;
      push_cmd(4'b0001, 32'h0002_0000, 8'd2);
      total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d want=1", fifo_count); end
      total++; if (q_op !== 4'h0)       begin bad++; $display("FAIL single_latency got=%h want=0", q_op); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (q_op !== 4'b0001) begin bad++; $display("FAIL single_op cyc=%0d got=%h want=1", i, q_op); end
         total++; if (h_input !== exp_h) begin bad++; $display("FAIL single_h cyc=%0d got=%h want=%h", i, h_input, exp_h); end
`ifdef QSEQ_H_DECAY_EN
         exp_h = exp_h >> 1;
`endif
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (q_op !== 4'h0) begin bad++; $display("FAIL single_gap cyc=%0d got=%h want=0", i, q_op); end
         if (i == 3) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_settle got=%b want=1", busy); end
         end
      end
      total++; if (busy !== 1'b0)         begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
      total++; if (ops_issued !== 16'd3)  begin bad++; $display("FAIL single_ops got=%0d want=3", ops_issued); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_op [9];
      int n;
      int got;
      exp_op = '{4'h1, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA};
      push_cmd(4'b0010, 32'h0, 8'd255);
      for (int i = 0; i < 8; i++) begin
         cmd_op = exp_op[i]; cmd_h = 32'(i); cmd_repeat = 8'd0; cmd_valid = 1'b1;
         tick();
      end
      cmd_op = exp_op[8]; cmd_h = 32'd8; cmd_repeat = 8'd0;
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL b2b_full_count got=%0d want=8", fifo_count); end
      total++; if (cmd_ready !== 1'b0)  begin bad++; $display("FAIL b2b_full_ready got=%b want=0", cmd_ready); end
      total++; if (q_op !== 4'b0010)    begin bad++; $display("FAIL b2b_stall_op got=%h want=2", q_op); end
      n = 0;
      while (!cmd_ready && n < 400) begin tick(); n++; end
      total++; if (cmd_ready !== 1'b1)  begin bad++; $display("FAIL b2b_ready_timeout got=%b want=1", cmd_ready); end
      total++; if (fifo_count !== 4'd7) begin bad++; $display("FAIL b2b_after_pop got=%0d want=7", fifo_count); end
      got = 0; n = 0;
      while (got < 9 && n < 100) begin
         if (q_op != 4'h0) begin
            total++; if (q_op !== exp_op[got]) begin bad++; $display("FAIL b2b_order idx=%0d got=%h want=%h", got, q_op, exp_op[got]); end
            total++; if (h_input !== 32'(got)) begin bad++; $display("FAIL b2b_h idx=%0d got=%h want=%h", got, h_input, got); end
            got++;
         end
         tick();
         cmd_valid = 1'b0;
         n++;
      end
      total++; if (got != 9) begin bad++; $display("FAIL b2b_issued got=%0d want=9", got); end
      wait_idle("b2b");
   endtask

   task automatic test_loss();
      resonance_active = 1'b1;
      push_cmd(4'b0010, 32'h0, 8'd255);
      push_cmd(4'b0001, 32'h0, 8'd0);
      push_cmd(4'b0100, 32'h0, 8'd0);
      push_cmd(4'b1000, 32'h0, 8'd0);
      total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL loss_queued got=%0d want=3", fifo_count); end
      resonance_active = 1'b0;
      repeat (15) tick();
      resonance_active = 1'b1;
      tick();
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL loss_15_no_fault got=%b want=0", fault); end
      resonance_active = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 15) begin
            total++; if (fault !== 1'b0) begin bad++; $display("FAIL loss_early got=%b want=0", fault); end
         end
      end
      total++; if (fault !== 1'b1)      begin bad++; $display("FAIL loss_fault got=%b want=1", fault); end
      total++; if (q_op !== 4'h0)       begin bad++; $display("FAIL loss_q_op got=%h want=0", q_op); end
      total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL loss_flush got=%0d want=0", fifo_count); end
      total++; if (cmd_ready !== 1'b0)  begin bad++; $display("FAIL loss_ready got=%b want=0", cmd_ready); end
   endtask

   task automatic test_fault_recovery();
      resonance_active = 1'b1;
      repeat (3) tick();
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL rec_sticky got=%b want=1", fault); end
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      total++; if (fault !== 1'b0)     begin bad++; $display("FAIL rec_clear got=%b want=0", fault); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rec_idle got=%b want=0", busy); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rec_ready got=%b want=1", cmd_ready); end
      push_cmd(4'b1000, 32'h0000_1234, 8'd1);
      tick();
      total++; if (q_op !== 4'b1000)       begin bad++; $display("FAIL rec_op got=%h want=8", q_op); end
      total++; if (h_input !== 32'h1234)   begin bad++; $display("FAIL rec_h got=%h want=1234", h_input); end
      tick();
      total++; if (q_op !== 4'b1000)       begin bad++; $display("FAIL rec_op2 got=%h want=8", q_op); end
      tick();
      total++; if (q_op !== 4'h0)          begin bad++; $display("FAIL rec_end got=%h want=0", q_op); end
      wait_idle("rec");
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL rec_idle_clear_fault got=%b want=0", fault); end
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rec_idle_clear_busy got=%b want=0", busy); end
      total++; if (q_op !== 4'h0)  begin bad++; $display("FAIL rec_idle_clear_op got=%h want=0", q_op); end
   endtask

   task automatic test_reset_mid();
      push_cmd(4'b0100, 32'h55, 8'd10);
      push_cmd(4'b0001, 32'h0, 8'd0);
      tick(); tick(); tick();
      total++; if (q_op !== 4'b0100) begin bad++; $display("FAIL rmid_pre got=%h want=4", q_op); end
      reset = 1'b1;
      tick();
      total++; if (q_op !== 4'h0)        begin bad++; $display("FAIL rmid_op got=%h want=0", q_op); end
      total++; if (fifo_count !== 4'd0)  begin bad++; $display("FAIL rmid_count got=%0d want=0", fifo_count); end
      total++; if (ops_issued !== 16'd0) begin bad++; $display("FAIL rmid_ops got=%0d want=0", ops_issued); end
      reset = 1'b0;
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
   endtask

   task automatic test_decay();
      logic [31:0] exp_h [4];
`ifdef QSEQ_H_DECAY_EN
      exp_h = '{32'h0008_0000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000};
`else
      exp_h = '{32'h0008_0000, 32'h0008_0000, 32'h0008_0000, 32'h0008_0000};
`endif
      push_cmd(4'b0001, 32'h0008_0000, 8'd3);
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (h_input !== exp_h[i]) begin bad++; $display("FAIL decay_h cyc=%0d got=%h want=%h", i, h_input, exp_h[i]); end
         total++; if (q_op !== 4'b0001)     begin bad++; $display("FAIL decay_op cyc=%0d got=%h want=1", i, q_op); end
      end
      tick();
      total++; if (h_input !== 32'h0) begin bad++; $display("FAIL decay_end got=%h want=0", h_input); end
      wait_idle("decay");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_loss();
      test_fault_recovery();
      test_reset_mid();
      test_decay();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
